skewed_mem_control: RTL and testbench
=====================================

// Module: skewed_mem_control
// PURPOSE
//  Parametrised address/enable sequencer for the systolic-array memory banks.
//  On a start pulse it walks num_row rows from base_addr with a programmable stride.
//  It drives one address and enable per lane (column) to the weight/input SRAM banks.
//  Optional skew mode staggers lane i by i cycles so data enters the array diagonally.
//  Adds stall and busy/done handshaking; row/col counts reach the full width_height.
// PARAMETERS
//  addr_width    8   bits per lane address
//  width_height  16  lane count (array dimension)
//  CW = $clog2(width_height)+1 (local); count width, holds 0..width_height inclusive
// PORTS
//  clk       in   1                         single clock, rising edge
//  reset     in   1                         synchronous, active-high
//  start     in   1                         pulse; begins a sequence when idle
//  base_addr in   addr_width                first row address (sampled on start)
//  stride    in   addr_width                address increment per row (sampled on start)
//  num_row   in   CW                        rows to issue, 0..width_height (sampled)
//  num_col   in   CW                        active lanes, 0..width_height (sampled)
//  skew      in   1                         1 = lane i delayed i cycles (sampled)
//  stall     in   1                         1 = freeze sequence this cycle
//  out_addr  out  addr_width*width_height   lane i at [i*addr_width +: addr_width]
//  out_en    out  width_height              per-lane read enable, bit i = lane i
//  busy      out  1                         sequence in progress
//  done      out  1                         one-cycle pulse at sequence end
// BEHAVIOUR
//  - All outputs registered; reset value 0 (out_addr, out_en, busy, done); FSM -> IDLE.
//  - FSM: IDLE -> RUN on start; RUN -> FIN after step T-1 issued; FIN -> IDLE next cycle.
//  - Operands (base, stride, num_row, num_col, skew) latched at start; later changes ignored.
//  - T = num_row if skew=0; T = num_row+num_col-1 if skew=1. Step counter t runs 0..T-1.
//  - start sampled at edge k: step t=0 visible cycle k+1; busy=1 from k+1 through step T-1.
//  - Lane i row index r = t (skew=0) or t-i (skew=1).
//  - Lane i enabled iff i<num_col and 0<=r<num_row.
//  - Lane i address = base_addr + r*stride, mod 2^addr_width (wraps silently).
//  - Disabled lanes drive addr 0. No multiplier needed: per-lane accumulators add stride.
//  - Cycle after step T-1: FIN, out_en=0, out_addr=0, busy=0, done=1 for exactly one cycle.
//  - stall=1 in RUN: t and addresses hold; out_en=0 that cycle; resumes same step after.
//  - stall in IDLE/FIN has no effect; stall never delays done once in FIN.
//  - start while busy or in FIN: ignored (no restart, no queueing).
//  - start in IDLE same cycle done is high is accepted (back-to-back, no idle gap required).
//  - num_row=0 or num_col=0: RUN skipped; done pulses cycle k+1, out_en stays 0, busy stays 0.
//  - num_row/num_col > width_height: clamped to width_height.
//  - reset has priority over start/stall; mid-sequence reset -> IDLE, outputs 0, no done.
// TESTING
//  1. skew=0,base=8'h10,stride=1,row=4,col=3 -> cycles1-4 en=0x0007 addr 10,11,12,13; cycle5 done.
//  2. skew=1,base=0,stride=2,row=3,col=3 -> T=5.
//     Lane0 en cycles1-3 addr0,2,4; lane2 en cycles3-5. done cycle6.
//  3. row=16,col=16,skew=0 -> 16 steps, en=0xFFFF; base=8'hF8,stride=1 wraps FF->00.
//  4. stall high cycles2-3 of test1 -> en=0 those cycles; addr 11 reissued cycle4; done cycle7.
//  5. num_row=0 -> done pulse cycle1, busy never 1; start during busy -> ignored, single done.
//  6. reset at step 2 of test1 -> next cycle all outputs 0, no done; new start works normally.

Source files
------------

// File: rtl/skewed_mem_control.sv
// Row/lane address sequencer for the systolic-array SRAM banks: walks num_row rows
// from base_addr by stride, one address/enable per lane, optionally skewed diagonally.
module skewed_mem_control #(
  parameter int addr_width   = 8,
  parameter int width_height = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [addr_width-1:0]              base_addr,
  input  logic [addr_width-1:0]              stride,
  input  logic [$clog2(width_height):0]      num_row,
  input  logic [$clog2(width_height):0]      num_col,
  input  logic                               skew,
  input  logic                               stall,
  output logic [addr_width*width_height-1:0] out_addr,
  output logic [width_height-1:0]            out_en,
  output logic                               busy,
  output logic                               done
);
  localparam int CW = $clog2(width_height) + 1;
  localparam int TW = CW + 1;
  localparam logic [CW-1:0] WHC = width_height[CW-1:0];

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]                               state_q, state_d;
  logic [TW-1:0]                            t_q, t_d;
  logic [addr_width-1:0]                    stride_q, stride_d;
  logic [CW-1:0]                            rows_q, rows_d, cols_q, cols_d;
  logic                                     skew_q, skew_d;
  logic [width_height-1:0][addr_width-1:0]  acc_q, acc_d;
  logic [addr_width*width_height-1:0]       out_addr_q, out_addr_d;
  logic [width_height-1:0]                  out_en_q, out_en_d;
  logic                                     busy_q, busy_d, done_q, done_d;

  logic                                     issue;
  logic [TW-1:0]                            src_t, span, lane_r, lane_i;
  logic [addr_width-1:0]                    src_stride;
  logic [CW-1:0]                            src_rows, src_cols, rows_in, cols_in;
  logic                                     src_skew, lane_on;
  logic [width_height-1:0][addr_width-1:0]  src_acc;

  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] v);
    return (v > WHC) ? WHC : v;
  endfunction

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    stride_d   = stride_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    skew_d     = skew_q;
    acc_d      = acc_q;
    out_addr_d = '0;
    out_en_d   = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;
    src_t      = t_q;
    src_stride = stride_q;
    src_rows   = rows_q;
    src_cols   = cols_q;
    src_skew   = skew_q;
    src_acc    = acc_q;
    rows_in    = clamp_cnt(num_row);
    cols_in    = clamp_cnt(num_col);
    span       = '0;
    lane_r     = '0;
    lane_i     = '0;
    lane_on    = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        stride_d = stride;
        rows_d   = rows_in;
        cols_d   = cols_in;
        skew_d   = skew;
        if (rows_in == '0 || cols_in == '0) begin
          done_d = 1'b1;
        end else begin
          // Step 0 is issued straight from the live inputs so it lands one cycle after start.
          issue      = 1'b1;
          src_t      = '0;
          src_stride = stride;
          src_rows   = rows_in;
          src_cols   = cols_in;
          src_skew   = skew;
          for (int i = 0; i < width_height; i++) src_acc[i] = base_addr;
        end
      end
      RUN: begin
        if (stall) busy_d = 1'b1;
        else       issue  = 1'b1;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      span = src_skew ? ({1'b0, src_rows} + {1'b0, src_cols} - TW'(1)) : {1'b0, src_rows};
      // Each lane keeps its own running address; it advances only on rows it actually issues.
      for (int i = 0; i < width_height; i++) begin
        lane_i  = TW'(i);
        lane_r  = src_skew ? (src_t - lane_i) : src_t;
        lane_on = (lane_i < {1'b0, src_cols}) && (!src_skew || src_t >= lane_i) &&
                  (lane_r < {1'b0, src_rows});
        out_en_d[i] = lane_on;
        out_addr_d[i*addr_width +: addr_width] = lane_on ? src_acc[i] : '0;
        acc_d[i] = lane_on ? (src_acc[i] + src_stride) : src_acc[i];
      end
      busy_d  = 1'b1;
      t_d     = src_t + TW'(1);
      state_d = (src_t == span - TW'(1)) ? FIN : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      t_q        <= '0;
      stride_q   <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      skew_q     <= 1'b0;
      acc_q      <= '0;
      out_addr_q <= '0;
      out_en_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      stride_q   <= stride_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      skew_q     <= skew_d;
      acc_q      <= acc_d;
      out_addr_q <= out_addr_d;
      out_en_q   <= out_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out_addr = out_addr_q;
  assign out_en   = out_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_skewed_mem_control.sv
// Bench for skewed_mem_control: vector table of sequences, reference model fills a
// per-cycle scoreboard queue, outputs compared #1 after each rising edge.
module tb_skewed_mem_control;
  localparam int AW = 8;
  localparam int WH = 16;

  logic           clk = 1'b0;
  logic           reset, start, skew, stall;
  logic [AW-1:0]  base_addr, stride;
  logic [4:0]     num_row, num_col;
  logic [127:0]   out_addr;
  logic [15:0]    out_en;
  logic           busy, done;

  skewed_mem_control #(.addr_width(AW), .width_height(WH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
    .num_row(num_row), .num_col(num_col), .skew(skew), .stall(stall),
    .out_addr(out_addr), .out_en(out_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  en;
    logic [127:0] addr;
    logic         busy;
    logic         done;
    logic         chk_addr;
  } exp_t;

  typedef struct {
    string       name;
    logic [7:0]  base;
    logic [7:0]  stride;
    logic [4:0]  rows;
    logic [4:0]  cols;
    logic        skew;
    int unsigned stall_m;  // bit j: stall sampled at edge j after start
    int unsigned start_m;  // bit j: extra start sampled at edge j after start
    bit          gap;      // append one idle cycle check
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic exp_t idle_e(logic d);
    exp_t e;
    e.en = '0; e.addr = '0; e.busy = 1'b0; e.done = d; e.chk_addr = 1'b1;
    return e;
  endfunction

  function automatic exp_t step_e(vec_t v, int s, int rows, int cols);
    exp_t e;
    int r;
    e.en = '0; e.addr = '0; e.busy = 1'b1; e.done = 1'b0; e.chk_addr = 1'b1;
    for (int i = 0; i < WH; i++) begin
      r = v.skew ? s - i : s;
      if (i < cols && r >= 0 && r < rows) begin
        e.en[i] = 1'b1;
        e.addr[i*8 +: 8] = 8'(int'(v.base) + r * int'(v.stride));
      end
    end
    return e;
  endfunction

  task automatic model_push(vec_t v);
    int rows, cols, tt, nxt, n;
    exp_t e;
    rows = (v.rows > 16) ? 16 : int'(v.rows);
    cols = (v.cols > 16) ? 16 : int'(v.cols);
    if (rows == 0 || cols == 0) begin
      sb.push_back(idle_e(1'b1));
    end else begin
      tt = v.skew ? rows + cols - 1 : rows;
      sb.push_back(step_e(v, 0, rows, cols));
      nxt = 1;
      n = 2;
      while (nxt < tt) begin
        if (v.stall_m[n]) begin
          e = idle_e(1'b0); e.busy = 1'b1; e.chk_addr = 1'b0;
          sb.push_back(e);
        end else begin
          sb.push_back(step_e(v, nxt, rows, cols));
          nxt++;
        end
        n++;
      end
      sb.push_back(idle_e(1'b1));
    end
    if (v.gap) sb.push_back(idle_e(1'b0));
  endtask

  task automatic check(string name);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
    end else begin
      e = sb.pop_front();
      if (out_en !== e.en || busy !== e.busy || done !== e.done ||
          (e.chk_addr && out_addr !== e.addr)) begin
        n_fail++;
        $display("FAIL %s t=%0t: got en=%h busy=%b done=%b addr=%h, want en=%h busy=%b done=%b addr=%h",
                 name, $time, out_en, busy, done, out_addr, e.en, e.busy, e.done, e.addr);
      end
    end
  endtask

  task automatic run(vec_t v);
    int len;
    model_push(v);
    len = sb.size();
    start = 1'b1; base_addr = v.base; stride = v.stride;
    num_row = v.rows; num_col = v.cols; skew = v.skew; stall = v.stall_m[0];
    for (int n = 1; n <= len; n++) begin
      @(posedge clk); #1;
      check(v.name);
      start = v.start_m[n+1];
      stall = v.stall_m[n+1];
      base_addr = 8'($urandom); stride = 8'($urandom);
      num_row = 5'($urandom); num_col = 5'($urandom); skew = 1'($urandom);
    end
    start = 1'b0; stall = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{"rowmode",   8'h10, 8'd1,   5'd4,  5'd3,  1'b0, 0,        0,            1'b1};
    tbl[1] = '{"skewed",    8'h00, 8'd2,   5'd3,  5'd3,  1'b1, 0,        0,            1'b1};
    tbl[2] = '{"full_wrap", 8'hF8, 8'd1,   5'd16, 5'd16, 1'b0, 0,        0,            1'b1};
    tbl[3] = '{"stall",     8'h10, 8'd1,   5'd4,  5'd3,  1'b0, 32'h0C,   0,            1'b1};
    tbl[4] = '{"zero_row",  8'h55, 8'd3,   5'd0,  5'd4,  1'b0, 0,        0,            1'b1};
    tbl[5] = '{"zero_col",  8'h55, 8'd3,   5'd5,  5'd0,  1'b1, 32'h06,   0,            1'b1};
    tbl[6] = '{"start_bsy", 8'h10, 8'd1,   5'd4,  5'd3,  1'b0, 0,        32'h24,       1'b1};
    tbl[7] = '{"clamp",     8'h01, 8'h90,  5'd20, 5'd31, 1'b0, 0,        0,            1'b1};
    tbl[8] = '{"b2b_a",     8'h20, 8'd4,   5'd2,  5'd5,  1'b0, 0,        0,            1'b0};
    tbl[9] = '{"b2b_b",     8'hFE, 8'd3,   5'd4,  5'd16, 1'b1, 32'h1000, 0,            1'b1};

    reset = 1'b1; start = 1'b0; stall = 1'b1; skew = 1'b1;
    base_addr = 8'hAA; stride = 8'h11; num_row = 5'd3; num_col = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(idle_e(1'b0));
    check("reset_state");
    reset = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    sb.push_back(idle_e(1'b0));
    check("idle");

    for (int k = 0; k < 10; k++) run(tbl[k]);

    // Mid-sequence reset: steps 0,1 appear, then reset before step 2 is issued.
    begin
      vec_t v;
      exp_t e;
      v = tbl[0];
      start = 1'b1; base_addr = v.base; stride = v.stride;
      num_row = v.rows; num_col = v.cols; skew = v.skew;
      @(posedge clk); #1;
      start = 1'b0;
      sb.push_back(step_e(v, 0, 4, 3)); check("rst_step0");
      @(posedge clk); #1;
      sb.push_back(step_e(v, 1, 4, 3)); check("rst_step1");
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.push_back(idle_e(1'b0)); check("rst_clear");
      repeat (3) begin
        @(posedge clk); #1;
        sb.push_back(idle_e(1'b0)); check("rst_no_done");
      end
      e = idle_e(1'b0);
      if (e.done !== 1'b0) $display("unexpected model state");
      run(tbl[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
